// File: rtl/ffbank_write_arbiter.sv
// Round-robin write arbiter for a preset-able register bank. It also sequences
// a full-bank all-ones preset sweep, which takes priority over requester writes.
module ffbank_write_arbiter #(
   parameter int NREQ  = 4,
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*AW-1:0]    req_addr,
   input  logic [NREQ*WIDTH-1:0] req_wdata,
   input  logic                  preset_req,
   output logic [NREQ-1:0]       gnt,
   output logic                  bank_we,
   output logic [AW-1:0]         bank_addr,
   output logic [WIDTH-1:0]      bank_wdata,
   output logic                  bank_preset,
   output logic                  busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_SWEEP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
   logic             sweep_pend_q, sweep_pend_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic             bank_we_q, bank_we_d;
   logic [AW-1:0]    bank_addr_q, bank_addr_d;
   logic [WIDTH-1:0] bank_wdata_q, bank_wdata_d;
   logic             bank_preset_q, bank_preset_d;

   logic             win_valid;
   logic [PW-1:0]    win_idx;

   function automatic int wrap_idx(input int base, input int off);
      int idx;
      idx = base + off;
      if (idx >= NREQ) idx = idx - NREQ;
      return idx;
   endfunction

   // Scan rr_ptr, rr_ptr+1, ... modulo NREQ; first set request wins.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int off = 0; off < NREQ; off++) begin
         if (!win_valid && req[wrap_idx(int'(rr_ptr_q), off)]) begin
            win_valid = 1'b1;
            win_idx   = PW'(wrap_idx(int'(rr_ptr_q), off));
         end
      end
   end

   always_comb begin
      // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      sweep_pend_d  = sweep_pend_q | (preset_req && (state_q != S_SWEEP));
      gnt_d         = '0;
      bank_we_d     = 1'b0;
      bank_addr_d   = '0;
      bank_wdata_d  = '0;
      bank_preset_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sweep_pend_q || preset_req) begin
               state_d       = S_SWEEP;
               sweep_pend_d  = 1'b0;
               bank_we_d     = 1'b1;
               bank_preset_d = 1'b1;
               bank_wdata_d  = '1;
            end else if (win_valid) begin
               state_d          = S_GRANT;
               gnt_d[win_idx]   = 1'b1;
               bank_we_d        = 1'b1;
               bank_addr_d      = req_addr[int'(win_idx)*AW +: AW];
               bank_wdata_d     = req_wdata[int'(win_idx)*WIDTH +: WIDTH];
               rr_ptr_d         = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
            end
         end
         S_GRANT: begin
            state_d = S_IDLE;
         end
         S_SWEEP: begin
            // bank_addr_q doubles as the sweep counter; it stops at DEPTH-1.
            if (bank_addr_q == AW'(DEPTH-1)) begin
               state_d = S_IDLE;
            end else begin
               bank_we_d     = 1'b1;
               bank_preset_d = 1'b1;
               bank_addr_d   = bank_addr_q + AW'(1);
               bank_wdata_d  = '1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= '0;
         sweep_pend_q  <= 1'b0;
         gnt_q         <= '0;
         bank_we_q     <= 1'b0;
         bank_addr_q   <= '0;
         bank_wdata_q  <= '0;
         bank_preset_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         sweep_pend_q  <= sweep_pend_d;
         gnt_q         <= gnt_d;
         bank_we_q     <= bank_we_d;
         bank_addr_q   <= bank_addr_d;
         bank_wdata_q  <= bank_wdata_d;
         bank_preset_q <= bank_preset_d;
      end
   end

   assign gnt         = gnt_q;
   assign bank_we     = bank_we_q;
   assign bank_addr   = bank_addr_q;
   assign bank_wdata  = bank_wdata_q;
   assign bank_preset = bank_preset_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ffbank_write_arbiter.sv
// Directed bench for ffbank_write_arbiter: grants, round-robin order, sweep
// priority and queuing, and asynchronous reset during a sweep.
module tb_ffbank_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        preset_req;
   logic [3:0]  gnt;
   logic        bank_we;
   logic [2:0]  bank_addr;
   logic [7:0]  bank_wdata;
   logic        bank_preset;
   logic        busy;

   logic [17:0] obs;
   logic [17:0] exp_v;
   int          total = 0;
   int          bad   = 0;

   ffbank_write_arbiter #(.NREQ(4), .DEPTH(8), .AW(3), .WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .preset_req  (preset_req),
      .gnt         (gnt),
      .bank_we     (bank_we),
      .bank_addr   (bank_addr),
      .bank_wdata  (bank_wdata),
      .bank_preset (bank_preset),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   assign obs = {gnt, bank_we, bank_preset, busy, bank_addr, bank_wdata};

   function automatic logic [17:0] ev(input logic [3:0] g, input logic we, input logic pr,
                                      input logic bz, input logic [2:0] a, input logic [7:0] d);
      return {g, we, pr, bz, a, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst        = 1'b1;
      req        = '0;
      preset_req = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      req        = 4'b1111;
      preset_req = 1'b1;
      req_addr   = 12'hFFF;
      req_wdata  = 32'hFFFF_FFFF;
      #1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs !== 18'h0) begin
            bad++;
            $display("FAIL reset_hold[%0d]: got %h want %h", k, obs, 18'h0);
         end
         tick();
      end
      apply_reset();
      total++;
      if (obs !== 18'h0) begin
         bad++;
         $display("FAIL reset_release: got %h want %h", obs, 18'h0);
      end
   endtask

   task automatic test_single_and_pointer();
      apply_reset();
      req_addr  = {3'd0, 3'd3, 3'd0, 3'd6};
      req_wdata = {8'h00, 8'hA5, 8'h00, 8'h5A};
      req       = 4'b0100;
      tick();
      exp_v = ev(4'b0100, 1'b1, 1'b0, 1'b1, 3'd3, 8'hA5);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL single_grant: got %h want %h", obs, exp_v);
      end
      req = '0;
      tick();
      total++;
      if (obs !== 18'h0) begin
         bad++;
         $display("FAIL single_idle: got %h want %h", obs, 18'h0);
      end
      // Pointer now at 3: requester 2 is skipped, scan wraps to 0.
      req = 4'b0101;
      tick();
      exp_v = ev(4'b0001, 1'b1, 1'b0, 1'b1, 3'd6, 8'h5A);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL pointer_persist: got %h want %h", obs, exp_v);
      end
      req = '0;
      tick();
      total++;
      if (obs !== 18'h0) begin
         bad++;
         $display("FAIL pointer_idle: got %h want %h", obs, 18'h0);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] addr_tab [4];
      logic [7:0] data_tab [4];
      int w;
      addr_tab = '{3'd1, 3'd2, 3'd5, 3'd6};
      data_tab = '{8'h11, 8'h22, 8'h33, 8'h44};
      apply_reset();
      req_addr  = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
      req_wdata = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
      req       = 4'b1111;
      for (int k = 0; k < 9; k++) begin
         tick();
         if (k % 2 == 0) begin
            w     = (k / 2) % 4;
            exp_v = ev(4'(1 << w), 1'b1, 1'b0, 1'b1, addr_tab[w], data_tab[w]);
         end else begin
            exp_v = 18'h0;
         end
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL round_robin[%0d]: got %h want %h", k, obs, exp_v);
         end
      end
      req = '0;
      tick();
   endtask

   task automatic test_sweep_priority();
      apply_reset();
      req_addr   = {3'd0, 3'd0, 3'd0, 3'd2};
      req_wdata  = {8'h00, 8'h00, 8'h00, 8'h77};
      req        = 4'b0001;
      preset_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         preset_req = (k == 3);
         exp_v = ev(4'b0000, 1'b1, 1'b1, 1'b1, 3'(k), 8'hFF);
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL sweep_cycle[%0d]: got %h want %h", k, obs, exp_v);
         end
      end
      tick();
      total++;
      if (obs !== 18'h0) begin
         bad++;
         $display("FAIL sweep_end_idle: got %h want %h", obs, 18'h0);
      end
      tick();
      exp_v = ev(4'b0001, 1'b1, 1'b0, 1'b1, 3'd2, 8'h77);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL sweep_then_grant: got %h want %h", obs, exp_v);
      end
      req = '0;
      for (int k = 0; k < 2; k++) begin
         tick();
         total++;
         if (obs !== 18'h0) begin
            bad++;
            $display("FAIL no_second_sweep[%0d]: got %h want %h", k, obs, 18'h0);
         end
      end
   endtask

   task automatic test_preset_during_grant();
      apply_reset();
      req_addr  = {3'd0, 3'd0, 3'd5, 3'd0};
      req_wdata = {8'h00, 8'h00, 8'h3C, 8'h00};
      req       = 4'b0010;
      tick();
      exp_v = ev(4'b0010, 1'b1, 1'b0, 1'b1, 3'd5, 8'h3C);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL pg_grant: got %h want %h", obs, exp_v);
      end
      req        = '0;
      preset_req = 1'b1;
      tick();
      preset_req = 1'b0;
      total++;
      if (obs !== 18'h0) begin
         bad++;
         $display("FAIL pg_idle: got %h want %h", obs, 18'h0);
      end
      tick();
      exp_v = ev(4'b0000, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL pg_sweep_start: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_reset_mid_sweep();
      apply_reset();
      preset_req = 1'b1;
      tick();
      preset_req = 1'b0;
      repeat (4) tick();
      exp_v = ev(4'b0000, 1'b1, 1'b1, 1'b1, 3'd4, 8'hFF);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL rms_cycle4: got %h want %h", obs, exp_v);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (obs !== 18'h0) begin
         bad++;
         $display("FAIL rms_async_drop: got %h want %h", obs, 18'h0);
      end
      tick();
      total++;
      if (obs !== 18'h0) begin
         bad++;
         $display("FAIL rms_held: got %h want %h", obs, 18'h0);
      end
      rst = 1'b0;
      tick();
      total++;
      if (obs !== 18'h0) begin
         bad++;
         $display("FAIL rms_no_resume: got %h want %h", obs, 18'h0);
      end
      req_addr  = {3'd0, 3'd0, 3'd4, 3'd1};
      req_wdata = {8'h00, 8'h00, 8'hBB, 8'hAA};
      req       = 4'b0011;
      tick();
      exp_v = ev(4'b0001, 1'b1, 1'b0, 1'b1, 3'd1, 8'hAA);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL rms_ptr_zero: got %h want %h", obs, exp_v);
      end
      req = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_and_pointer();
      test_round_robin();
      test_sweep_priority();
      test_preset_during_grant();
      test_reset_mid_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
